// File: rtl/bus_pkg.sv
// Shared definitions for the bus pipeline slice.
//   ST_EMPTY / ST_ONE / ST_FULL : slice state encoding; each value equals the beat count.
//   BUS_DATA_W / BUS_CNT_W      : default payload and counter widths.
package bus_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned BUS_DATA_W = 8;
  localparam int unsigned BUS_CNT_W  = 16;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StOne   = ST_ONE,
    StFull  = ST_FULL
  } skid_state_e;

endpackage

// File: rtl/bus_hs_counter.sv
// Wrapping handshake counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   clr   : synchronous clear
//   en    : increment by one this cycle
//   count : current value, wraps modulo 2^W
module bus_hs_counter
  import bus_pkg::*;
#(
  parameter int unsigned W = BUS_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bus_skid_slice.sv
// Registered valid/ready pipeline slice with a one-entry skid buffer.
//   clk, rst            : clock and synchronous active-high reset
//   flush               : synchronous flush, drops every buffered beat
//   s_valid_i/s_data_i  : upstream beat, s_ready_o is its registered ready
//   m_valid_o/m_data_o  : downstream beat (registered), m_ready_i is its ready
//   occupancy_o         : beats held (0..2)
//   in_cnt_o/out_cnt_o  : wrapping counts of accepted / delivered beats
module bus_skid_slice
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_DATA_W,
  parameter int unsigned CNT_W  = BUS_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  in_cnt_o,
  output logic [CNT_W-1:0]  out_cnt_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              s_ready_q;
  logic              m_valid_q;
  logic              acc, del;

  assign acc = s_valid_i & s_ready_q;
  assign del = m_valid_q & m_ready_i;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    skid_d   = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          m_data_d = s_data_i;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (acc && del) begin
          m_data_d = s_data_i;
        end else if (acc) begin
          // Output is stalled: park the new beat behind it.
          skid_d  = s_data_i;
          state_d = StFull;
        end else if (del) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (del) begin
          m_data_d = skid_q;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Data registers are left alone; they are don't-care once invalid.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != StFull);
      m_valid_q <= (state_d != StEmpty);
      m_data_q  <= m_data_d;
      skid_q    <= skid_d;
    end
  end

  assign s_ready_o   = s_ready_q;
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  // State encoding doubles as the beat count.
  assign occupancy_o = state_q;

  bus_hs_counter #(
    .W (CNT_W)
  ) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (acc),
    .count (in_cnt_o)
  );

  bus_hs_counter #(
    .W (CNT_W)
  ) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (del),
    .count (out_cnt_o)
  );

endmodule

// File: tb/tb_bus_skid_slice.sv
// Scoreboard bench for bus_skid_slice. Two instances share all inputs: one with the
// default 16-bit counters and one with 4-bit counters to exercise wrap-around.
module tb_bus_skid_slice;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       m_ready = 1'b0;

  logic        s_ready, m_valid, s_ready_w, m_valid_w;
  logic [7:0]  m_data, m_data_w;
  logic [1:0]  occ, occ_w;
  logic [15:0] in_cnt, out_cnt;
  logic [3:0]  in_cnt_w, out_cnt_w;

  always #5 clk = ~clk;

  bus_skid_slice #(.DATA_W(8), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .s_valid_i (s_valid), .s_data_i (s_data), .s_ready_o (s_ready),
    .m_valid_o (m_valid), .m_data_o (m_data), .m_ready_i (m_ready),
    .occupancy_o (occ), .in_cnt_o (in_cnt), .out_cnt_o (out_cnt)
  );

  bus_skid_slice #(.DATA_W(8), .CNT_W(4)) dut_w (
    .clk (clk), .rst (rst), .flush (flush),
    .s_valid_i (s_valid), .s_data_i (s_data), .s_ready_o (s_ready_w),
    .m_valid_o (m_valid_w), .m_data_o (m_data_w), .m_ready_i (m_ready),
    .occupancy_o (occ_w), .in_cnt_o (in_cnt_w), .out_cnt_o (out_cnt_w)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a FIFO of capacity two plus plain integer counters.
  logic [7:0] exp_q[$];
  int         in_m = 0;
  int         out_m = 0;
  bit         ready_exp = 1'b0;
  bit         model_on = 1'b0;
  bit         hold_prev = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared at the falling edge, then the model advances by the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    bit acc, del;
    if (model_on) begin
      chk("occupancy", 32'(occ), 32'(exp_q.size()));
      chk("occupancy_w", 32'(occ_w), 32'(exp_q.size()));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(ready_exp));
      chk("s_ready_w", 32'(s_ready_w), 32'(ready_exp));
      if (exp_q.size() != 0) begin
        chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("m_data_w", 32'(m_data_w), 32'(exp_q[0]));
      end
      chk("in_cnt", 32'(in_cnt), in_m % 65536);
      chk("out_cnt", 32'(out_cnt), out_m % 65536);
      chk("in_cnt_w", 32'(in_cnt_w), in_m % 16);
      chk("out_cnt_w", 32'(out_cnt_w), out_m % 16);
      if (hold_prev) begin
        chk("stable_valid", 32'(m_valid), 32'd1);
        chk("stable_data", 32'(m_data), 32'(hold_data));
      end
    end
    if (rst) begin
      exp_q.delete();
      in_m = 0;
      out_m = 0;
      ready_exp = 1'b0;
      hold_prev = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      acc = s_valid && ready_exp;
      del = (exp_q.size() != 0) && m_ready;
      hold_prev = (exp_q.size() != 0) && !m_ready && !flush;
      hold_data = m_data;
      if (del) begin
        void'(exp_q.pop_front());
        out_m++;
      end
      if (acc) begin
        exp_q.push_back(s_data);
        in_m++;
      end
      if (flush) exp_q.delete();
      ready_exp = (exp_q.size() < 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the slice takes it.
  task automatic send(input logic [7:0] d, input logic mr);
    bit taken;
    taken = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    m_ready = mr;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = s_ready;
      step();
    end
    if (!taken) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: beat %0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    int in_before;
    // Reset release
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready_low", 32'(s_ready), 32'd0);
    step();
    chk("ready_after_rst", 32'(s_ready), 32'd1);
    chk("valid_after_rst", 32'(m_valid), 32'd0);
    chk("cnt_after_rst", 32'(in_cnt), 32'd0);

    // Streaming
    for (int i = 0; i <= 16; i++) send(8'(i), 1'b1);
    drain();
    chk("stream_in_cnt", 32'(in_cnt), 32'd17);
    chk("stream_out_cnt", 32'(out_cnt), 32'd17);
    chk("stream_in_cnt_w", 32'(in_cnt_w), 32'd1);

    // Backpressure
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h07;
    repeat (3) step();
    chk("bp_ready", 32'(s_ready), 32'd0);
    chk("bp_occ", 32'(occ), 32'd2);
    chk("bp_data", 32'(m_data), 32'h05);
    send(8'h07, 1'b1);
    drain();
    chk("bp_counts", 32'(in_cnt - out_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 3) != 0 || (i % 97) > 40);
      step();
    end
    drain();

    // Flush while full
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    s_valid = 1'b0;
    chk("pre_flush_occ", 32'(occ), 32'd2);
    in_before = int'(in_cnt);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_occ", 32'(occ), 32'd0);
    chk("flush_valid", 32'(m_valid), 32'd0);
    chk("flush_ready", 32'(s_ready), 32'd1);
    chk("flush_in_cnt", 32'(in_cnt), 32'(in_before));
    step();

    // Counter wrap with 4-bit counters, then reset in the middle of a transfer
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 18; i++) send(8'(8'h20 + i), 1'b1);
    drain();
    chk("wrap_in_cnt_w", 32'(in_cnt_w), 32'd2);
    chk("wrap_out_cnt_w", 32'(out_cnt_w), 32'd2);
    chk("wrap_in_cnt", 32'(in_cnt), 32'd18);
    send(8'h55, 1'b0);
    s_valid = 1'b0;
    chk("mid_occ_one", 32'(occ), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_occ", 32'(occ), 32'd0);
    chk("mid_rst_in", 32'(in_cnt), 32'd0);
    chk("mid_rst_out", 32'(out_cnt_w), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_release", 32'(s_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
